// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 8-digit seven-segment scanner.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] BLANK        = 8'hFF;
  localparam int         DEF_SCAN_DIV = 1000;
  localparam int         DEF_GAP      = 16;

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Hex digit to active-low seven-segment pattern {a,b,c,d,e,f,g,dp}; dp is always off here.
module seg_scan_ctrl_hex7seg (
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    case (hex)
      4'h0: seg = {7'b0000001, 1'b1};
      4'h1: seg = {7'b1001111, 1'b1};
      4'h2: seg = {7'b0010010, 1'b1};
      4'h3: seg = {7'b0000110, 1'b1};
      4'h4: seg = {7'b1001100, 1'b1};
      4'h5: seg = {7'b0100100, 1'b1};
      4'h6: seg = {7'b0100000, 1'b1};
      4'h7: seg = {7'b0001111, 1'b1};
      4'h8: seg = {7'b0000000, 1'b1};
      4'h9: seg = {7'b0000100, 1'b1};
      4'hA: seg = {7'b0001000, 1'b1};
      4'hB: seg = {7'b1100000, 1'b1};
      4'hC: seg = {7'b0110001, 1'b1};
      4'hD: seg = {7'b1000010, 1'b1};
      4'hE: seg = {7'b0110000, 1'b1};
      4'hF: seg = {7'b0111000, 1'b1};
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: time-multiplexed slots with blanking gap
// and frame-synchronous double buffering of the displayed data.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int GAP      = DEF_GAP,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  en_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start,
  output logic        pending
);

  if (!((SCAN_DIV > GAP) && (GAP >= 1) &&
        (longint'(SCAN_DIV) < (longint'(1) << CNT_W)))) begin : g_bad_params
    $error("seg_scan_ctrl: need GAP >= 1, SCAN_DIV > GAP, SCAN_DIV < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - GAP - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

  state_e           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] shd_data_q, shd_data_d;
  logic [7:0]  shd_en_q, shd_en_d;
  logic [7:0]  shd_dp_q, shd_dp_d;
  logic [31:0] pnd_data_q, pnd_data_d;
  logic [7:0]  pnd_en_q, pnd_en_d;
  logic [7:0]  pnd_dp_q, pnd_dp_d;
  logic        pending_q, pending_d;

  logic [7:0] seg_q, seg_d;
  logic [7:0] an_q, an_d;
  logic       frame_start_q, frame_start_d;

  logic [3:0] cur_digit;
  logic [7:0] dec_seg;
  logic       boundary;

  assign cur_digit = shd_data_q[{slot_q, 2'b00} +: 4];

  seg_scan_ctrl_hex7seg u_seg (
    .hex (cur_digit),
    .seg (dec_seg)
  );

  // Last GAP cycle of slot 7: the only point where the shadow set may change.
  assign boundary = (state_q == ST_GAP) && (slot_q == 3'd7) && (cnt_q == SLOT_LAST);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    shd_data_d = shd_data_q;
    shd_en_d   = shd_en_q;
    shd_dp_d   = shd_dp_q;
    pnd_data_d = pnd_data_q;
    pnd_en_d   = pnd_en_q;
    pnd_dp_d   = pnd_dp_q;
    pending_d  = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shd_data_d = data_in;
          shd_en_d   = en_in;
          shd_dp_d   = dp_in;
          state_d    = ST_SHOW;
          slot_d     = 3'd0;
          cnt_d      = '0;
        end
      end
      ST_SHOW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          slot_d  = slot_q + 3'd1;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = 3'd0;
        cnt_d   = '0;
      end
    endcase

    if (state_q != ST_IDLE) begin
      if (boundary) begin
        if (load) begin
          shd_data_d = data_in;
          shd_en_d   = en_in;
          shd_dp_d   = dp_in;
        end else if (pending_q) begin
          shd_data_d = pnd_data_q;
          shd_en_d   = pnd_en_q;
          shd_dp_d   = pnd_dp_q;
        end
        pending_d = 1'b0;
      end else if (load) begin
        pnd_data_d = data_in;
        pnd_en_d   = en_in;
        pnd_dp_d   = dp_in;
        pending_d  = 1'b1;
      end
    end
  end

  // Output stage sees the same state/slot that the pins will reflect one cycle later.
  always_comb begin
    an_d          = BLANK;
    seg_d         = BLANK;
    frame_start_d = 1'b0;
    if (state_q == ST_SHOW) begin
      if (shd_en_q[slot_q]) begin
        an_d[slot_q] = 1'b0;
        seg_d        = dec_seg & {7'h7F, ~shd_dp_q[slot_q]};
      end
      frame_start_d = (slot_q == 3'd0) && (cnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      slot_q        <= 3'd0;
      cnt_q         <= '0;
      shd_data_q    <= '0;
      shd_en_q      <= '0;
      shd_dp_q      <= '0;
      pnd_data_q    <= '0;
      pnd_en_q      <= '0;
      pnd_dp_q      <= '0;
      pending_q     <= 1'b0;
      seg_q         <= BLANK;
      an_q          <= BLANK;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      shd_data_q    <= shd_data_d;
      shd_en_q      <= shd_en_d;
      shd_dp_q      <= shd_dp_d;
      pnd_data_q    <= pnd_data_d;
      pnd_en_q      <= pnd_en_d;
      pnd_dp_q      <= pnd_dp_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model, per-cycle compare, directed scenarios, random tail.
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int GP = 2;
  localparam int FR = 8 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  en_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        frame_start;
  logic        pending;

  seg_scan_ctrl #(.SCAN_DIV(SD), .GAP(GP), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .en_in       (en_in),
    .dp_in       (dp_in),
    .load        (load),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: running flag plus cycle count since the starting load; position in frame is m_t % FR.
  bit          m_run = 0;
  int          m_t = 0;
  logic [31:0] m_sd = '0, m_pd = '0;
  logic [7:0]  m_se = '0, m_sp = '0, m_pe = '0, m_pp = '0;
  bit          m_pend = 0;
  logic [7:0]  exp_an = 8'hFF, exp_seg = 8'hFF;
  logic        exp_fs = 1'b0, exp_pend = 1'b0;
  bit          chk_en = 0;
  int          cyc = 0;
  int          rst_cnt = 0;

  function automatic logic [6:0] dec7(input logic [3:0] h);
    logic [6:0] r;
    case (h)
      4'h0: r = 7'b0000001;  4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;  4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;  4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;  4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;  4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;  4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;  4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;  default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : model
    int p, s, w;
    cyc = cyc + 1;
    if (rst) begin
      m_run = 0; m_t = 0; m_pend = 0;
      m_sd = '0; m_se = '0; m_sp = '0; m_pd = '0; m_pe = '0; m_pp = '0;
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_fs = 1'b0; exp_pend = 1'b0;
      rst_cnt = rst_cnt + 1;
      chk_en = 1;
    end else begin
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_fs = 1'b0;
      if (m_run) begin
        p = m_t % FR; s = p / SD; w = p % SD;
        if (w < SD - GP && m_se[s]) begin
          exp_an  = ~(8'h01 << s);
          exp_seg = {dec7(m_sd[4*s +: 4]), ~m_sp[s]};
        end
        exp_fs = (p == 0);
        if (p == FR - 1) begin
          if (load) begin
            m_sd = data_in; m_se = en_in; m_sp = dp_in;
          end else if (m_pend) begin
            m_sd = m_pd; m_se = m_pe; m_sp = m_pp;
          end
          m_pend = 0;
        end else if (load) begin
          m_pd = data_in; m_pe = en_in; m_pp = dp_in; m_pend = 1;
        end
        m_t = m_t + 1;
      end else if (load) begin
        m_sd = data_in; m_se = en_in; m_sp = dp_in;
        m_run = 1; m_t = 0;
      end
      exp_pend = m_pend;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  int last_fs = -1;
  int seen_rst = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (seen_rst != rst_cnt) begin
        last_fs  = -1;
        seen_rst = rst_cnt;
      end
      chk("an", an, exp_an);
      chk("seg", seg, exp_seg);
      chk("frame_start", frame_start, exp_fs);
      chk("pending", pending, exp_pend);
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, FR);
        last_fs = cyc;
      end
    end
  end

  task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    load = 1'b1; data_in = d; en_in = e; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge whose expected outputs reflect frame position pos.
  task automatic wait_pos(input int pos);
    int n = 0;
    while (!(m_run && ((m_t - 1) % FR) == pos) && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests = tests + 1;
    if (n >= 300) begin
      fails = fails + 1;
      $display("FAIL wait_pos: position %0d not reached within 300 cycles", pos);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_pending", pending, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_an", an, 8'hFF);

    // Scenario 1: all digits, no dp
    do_load(32'h76543210, 8'hFF, 8'h00);
    @(negedge clk);
    chk("s1_seg0", seg, 8'h03);
    chk("s1_an0", an, 8'hFE);
    chk("s1_fs", frame_start, 1'b1);
    chk("s1_model_seg0", exp_seg, 8'h03);
    repeat (8) @(negedge clk);
    chk("s1_seg1", seg, 8'h9F);
    chk("s1_an1", an, 8'hFD);
    wait_pos(6);
    chk("s1_gap_an", an, 8'hFF);

    // Scenario 2: upper four digits disabled
    wait_pos(10);
    do_load(32'h76543210, 8'h0F, 8'h00);
    wait_pos(63);
    wait_pos(32);
    chk("s2_an_off", an, 8'hFF);
    chk("s2_seg_off", seg, 8'hFF);

    // Scenario 3: digit 0 = 8 with dp
    do_load(32'h76543218, 8'hFF, 8'h01);
    wait_pos(63);
    wait_pos(0);
    chk("s3_seg_8dp", seg, 8'h00);
    chk("s3_model_8dp", exp_seg, 8'h00);

    // Scenario 4: two loads in one frame, last wins at boundary
    wait_pos(24);
    do_load(32'hAAAAAAAA, 8'hFF, 8'h00);
    chk("s4_pending_set", pending, 1'b1);
    wait_pos(40);
    do_load(32'hBBBBBBBB, 8'hFF, 8'h00);
    wait_pos(56);
    chk("s4_old_frame", seg, 8'h1F);
    wait_pos(62);
    chk("s4_pending_hold", pending, 1'b1);
    wait_pos(0);
    chk("s4_seg_b", seg, 8'hC1);
    chk("s4_model_b", exp_seg, 8'hC1);
    chk("s4_pending_clr", pending, 1'b0);

    // Scenario 5: load coincident with the boundary cycle
    wait_pos(62);
    do_load(32'h00000005, 8'h01, 8'h00);
    chk("s5_pending", pending, 1'b0);
    @(negedge clk);
    chk("s5_seg5", seg, 8'h49);
    chk("s5_an0", an, 8'hFE);
    wait_pos(8);
    chk("s5_an_off", an, 8'hFF);

    // Scenario 6: reset mid-SHOW of slot 2, with a load that must be ignored
    do_load(32'h76543210, 8'hFF, 8'h00);
    wait_pos(63);
    wait_pos(17);
    chk("s6_pre_an", an, 8'hFB);
    rst = 1'b1; load = 1'b1; data_in = 32'h12345678; en_in = 8'hFF;
    @(negedge clk);
    chk("s6_an", an, 8'hFF);
    chk("s6_seg", seg, 8'hFF);
    rst = 1'b0; load = 1'b0;
    repeat (20) @(negedge clk);
    chk("s6_idle_an", an, 8'hFF);
    chk("s6_idle_fs", frame_start, 1'b0);

    // Random tail
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 599) == 0);
      load    = ($urandom_range(0, 29) == 0);
      data_in = $urandom;
      en_in   = 8'($urandom);
      dp_in   = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; load = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
